// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous SRAM among NUM_REQ requesters.
// Optional atomic lock support is compiled in with `define SRAM_ARB_LOCK_EN.
module sram_rr_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LOCK_MAX   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             sram_cs,
    output logic                             sram_we,
    output logic [ADDR_WIDTH-1:0]            sram_address,
    output logic [DATA_WIDTH-1:0]            sram_data_in,
    input  logic [DATA_WIDTH-1:0]            sram_data_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_WIDTH-1:0] w_addr    [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata   [NUM_REQ];
    logic [PTR_W-1:0]      w_off_idx [NUM_REQ];
    logic [NUM_REQ-1:0]    w_off_req;
    logic [NUM_REQ-1:0]    w_gnt;

    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_rr_idx;
    logic [PTR_W-1:0]      w_win_idx;
    logic [PTR_W-1:0]      w_ptr_next;
    logic                  w_rr_found;
    logic                  w_hold;
    logic                  w_win_valid;
    logic                  w_win_we;

    logic                  r_sram_cs;
    logic                  r_sram_we;
    logic [ADDR_WIDTH-1:0] r_sram_address;
    logic [DATA_WIDTH-1:0] r_sram_data_in;
    logic [NUM_REQ-1:0]    r_rd_pend;
    logic [NUM_REQ-1:0]    r_rvalid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [PTR_W:0] w_sum;

            assign w_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];

            // Requester index at scan offset gi from the pointer, wrapped modulo NUM_REQ.
            assign w_sum = {1'b0, r_ptr} + (PTR_W+1)'(gi);
            assign w_off_idx[gi] = (w_sum >= (PTR_W+1)'(NUM_REQ))
                                 ? PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ))
                                 : PTR_W'(w_sum);
            assign w_off_req[gi] = req[w_off_idx[gi]];

            assign w_gnt[gi] = w_win_valid && (w_win_idx == PTR_W'(gi));
        end
    endgenerate

    // Lowest scan offset with an active request wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_off_req[k]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_off_idx[k];
            end
        end
    end

`ifdef SRAM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    logic [PTR_W-1:0] r_owner;
    logic [CNT_W-1:0] r_count;
    logic             w_lock_start;

    // A locked owner that drops req hands the bus back to normal arbitration at once.
    assign w_hold       = (r_state == ST_LOCK) && req[r_owner];
    assign w_lock_start = w_rr_found && req_lock[w_rr_idx] && (LOCK_MAX > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ARB;
            r_owner <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_LOCK: begin
                    if (w_hold) begin
                        if (req_lock[r_owner] && ((r_count + 1'b1) < CNT_W'(LOCK_MAX))) begin
                            r_count <= r_count + 1'b1;
                        end else begin
                            r_state <= ST_ARB;
                            r_count <= '0;
                        end
                    end else if (w_lock_start) begin
                        r_owner <= w_rr_idx;
                        r_count <= CNT_W'(1);
                    end else begin
                        r_state <= ST_ARB;
                        r_count <= '0;
                    end
                end
                default: begin
                    if (w_lock_start) begin
                        r_state <= ST_LOCK;
                        r_owner <= w_rr_idx;
                        r_count <= CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign w_win_idx = w_hold ? r_owner : w_rr_idx;
`else
    logic w_unused_lock;

    assign w_unused_lock = ^req_lock;
    assign w_hold        = 1'b0;
    assign w_win_idx     = w_rr_idx;
`endif

    assign w_win_valid = w_hold || w_rr_found;
    assign w_win_we    = req_we[w_win_idx];
    assign w_ptr_next  = (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_win_valid) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Address and data hold their last value on idle cycles; only cs/we return low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sram_cs      <= 1'b0;
            r_sram_we      <= 1'b0;
            r_sram_address <= '0;
            r_sram_data_in <= '0;
            r_rd_pend      <= '0;
            r_rvalid       <= '0;
        end else begin
            r_sram_cs <= w_win_valid;
            r_sram_we <= w_win_valid && w_win_we;
            if (w_win_valid) begin
                r_sram_address <= w_addr[w_win_idx];
                r_sram_data_in <= w_wdata[w_win_idx];
            end
            r_rd_pend <= (w_win_valid && !w_win_we) ? w_gnt : '0;
            r_rvalid  <= r_rd_pend;
        end
    end

    assign gnt          = w_gnt;
    assign rvalid       = r_rvalid;
    assign rdata        = sram_data_out;
    assign sram_cs      = r_sram_cs;
    assign sram_we      = r_sram_we;
    assign sram_address = r_sram_address;
    assign sram_data_in = r_sram_data_in;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural SRAM.
module tb_sram_rr_arbiter;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int LMAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N-1:0]      req_we;
    logic [N-1:0]      req_lock;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic              sram_cs;
    logic              sram_we;
    logic [AW-1:0]     sram_address;
    logic [DW-1:0]     sram_data_in;
    logic [DW-1:0]     sram_data_out;

    logic [AW-1:0]     a [N];
    logic [DW-1:0]     d [N];

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a[i];
            req_wdata[i*DW +: DW] = d[i];
        end
    end

    sram_rr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LOCK_MAX   (LMAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_we        (req_we),
        .req_lock      (req_lock),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .sram_cs       (sram_cs),
        .sram_we       (sram_we),
        .sram_address  (sram_address),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out)
    );

    // Behavioural single-port synchronous SRAM with registered read.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_address] <= sram_data_in;
            else         sram_data_out     <= mem[sram_address];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: arbitration state, shadow memory and expected pipeline outputs.
    int            m_ptr;
    bit            m_locked;
    int            m_owner;
    int            m_count;
    logic [DW-1:0] shadow [256];
    logic          e_cs, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [N-1:0]  e_rv1, e_rv;
    logic [DW-1:0] e_rd1, e_rd;

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_owner = 0; m_count = 0;
        e_cs = 0; e_we = 0; e_addr = '0; e_din = '0;
        e_rv1 = '0; e_rv = '0; e_rd1 = '0; e_rd = '0;
    endtask

    function automatic int model_pick();
        int idx;
`ifdef SRAM_ARB_LOCK_EN
        if (m_locked && req[m_owner]) return m_owner;
`endif
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_edge(input int w);
        e_rv  = e_rv1;
        e_rd  = e_rd1;
        e_rv1 = '0;
        if (m_locked && !req[m_owner]) m_locked = 0;
        if (w < 0) begin
            e_cs = 0;
            e_we = 0;
        end else begin
            e_cs   = 1;
            e_we   = req_we[w];
            e_addr = a[w];
            e_din  = d[w];
            if (req_we[w]) begin
                shadow[a[w]] = d[w];
            end else begin
                e_rv1 = N'(1) << w;
                e_rd1 = shadow[a[w]];
            end
            m_ptr = (w + 1) % N;
`ifdef SRAM_ARB_LOCK_EN
            if (m_locked) begin
                if (req_lock[w] && (m_count + 1 < LMAX)) m_count++;
                else m_locked = 0;
            end else if (req_lock[w] && LMAX > 1) begin
                m_locked = 1;
                m_owner  = w;
                m_count  = 1;
            end
`endif
        end
    endtask

    // One clock: check grant before the edge, outputs 1 ns after it, return at next negedge.
    task automatic cycle(output int w);
        logic [N-1:0] exp_g;
        #1;
        w = model_pick();
        exp_g = (w < 0) ? '0 : (N'(1) << w);
        check_val("gnt", 32'(gnt), 32'(exp_g));
        @(posedge clk);
        model_edge(w);
        if (w >= 0)
            $display("txn t=%0t req%0d %s addr=%02h data=%02h", $time, w,
                     req_we[w] ? "WR" : "RD", a[w], req_we[w] ? d[w] : e_rd1);
        #1;
        check_val("sram_cs", 32'(sram_cs), 32'(e_cs));
        check_val("sram_we", 32'(sram_we), 32'(e_we));
        if (e_cs) begin
            check_val("sram_address", 32'(sram_address), 32'(e_addr));
            check_val("sram_data_in", 32'(sram_data_in), 32'(e_din));
        end
        check_val("rvalid", 32'(rvalid), 32'(e_rv));
        if (e_rv != '0) check_val("rdata", 32'(rdata), 32'(e_rd));
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0; req_we = '0; req_lock = '0;
        rst_n = 1'b0;
        #2;
        check_val("rst_gnt", 32'(gnt), 32'(0));
        check_val("rst_cs", 32'(sram_cs), 32'(0));
        check_val("rst_we", 32'(sram_we), 32'(0));
        check_val("rst_addr", 32'(sram_address), 32'(0));
        check_val("rst_din", 32'(sram_data_in), 32'(0));
        check_val("rst_rvalid", 32'(rvalid), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    int w;
    int seq [6];
    int exp_lock_seq [5];
    int last_w;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        model_reset();
        do_reset();

        // Write then read back the same cell through requester 0.
        req = 3'b001; req_we = 3'b001; a[0] = 8'h10; d[0] = 8'hA5;
        cycle(w);
        check_val("wr_winner", 32'(w), 32'(0));
        req_we = 3'b000;
        cycle(w);
        check_val("rd_winner", 32'(w), 32'(0));
        req = '0;
        cycle(w);
        check_val("raw_rvalid", 32'(rvalid), 32'(3'b001));
        check_val("raw_rdata", 32'(rdata), 32'(8'hA5));
        cycle(w);

        // All three requesting reads: strict rotation from a fresh pointer.
        do_reset();
        req = 3'b111; req_we = 3'b000;
        for (int i = 0; i < N; i++) a[i] = 8'(8'h20 + i);
        for (int k = 0; k < 6; k++) begin
            cycle(w);
            seq[k] = w;
        end
        for (int k = 0; k < 6; k++) check_val("rr_seq", 32'(seq[k]), 32'(k % 3));
        req = '0;
        cycle(w);
        cycle(w);

        // Pointer at 2 with requesters 0 and 1 pending.
        req = 3'b010;
        cycle(w);
        req = 3'b011;
        cycle(w);
        check_val("ptr2_first", 32'(w), 32'(0));
        cycle(w);
        check_val("ptr2_second", 32'(w), 32'(1));
        req = 3'b111;
        cycle(w);
        check_val("ptr2_end", 32'(w), 32'(2));
        req = '0;
        cycle(w);
        cycle(w);

        // Reset during the SRAM cycle of a read by requester 1.
        req = 3'b010; req_we = 3'b000; a[1] = 8'h10;
        cycle(w);
        req = '0;
        rst_n = 1'b0;
        #1;
        check_val("midrst_cs", 32'(sram_cs), 32'(0));
        check_val("midrst_rvalid", 32'(rvalid), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(w);
            check_val("midrst_no_rvalid", 32'(rvalid), 32'(0));
        end

        // Requester 0 asks for a lock while requester 1 keeps requesting.
`ifdef SRAM_ARB_LOCK_EN
        exp_lock_seq = '{0, 0, 0, 0, 1};
`else
        exp_lock_seq = '{0, 1, 0, 1, 0};
`endif
        do_reset();
        req = 3'b011; req_we = 3'b000; req_lock = 3'b001;
        for (int k = 0; k < 5; k++) begin
            cycle(w);
            check_val("lock_seq", 32'(w), 32'(exp_lock_seq[k]));
        end
        req = '0; req_lock = '0;
        cycle(w);
        cycle(w);

        // Randomized traffic: each requester holds its request until granted.
        last_w = -1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || last_w == i) begin
                    req[i]      = ($urandom_range(0, 99) < 55);
                    req_we[i]   = $urandom_range(0, 1) == 1;
                    req_lock[i] = ($urandom_range(0, 3) == 0);
                    a[i]        = 8'($urandom_range(0, 15));
                    d[i]        = 8'($urandom);
                end
            end
            cycle(w);
            last_w = w;
        end
        req = '0;
        cycle(w);
        cycle(w);
        cycle(w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
